// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: elastic pipeline register with a valid/ready handshake, flush,
// a configurable data reset value and a saturating stall counter.
// Build option PIPE_REG_HS_SKID_EN: when defined, a two-entry skid buffer with
// a registered p_ready is built. When undefined, there is a single entry and
// p_ready is combinational.
module pipe_reg_hs #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_VAL = '0,
  parameter int             CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic [N-1:0]     p_data,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [N-1:0]     q_data,
  output logic [CNT_W-1:0] stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic in_xfer;
  logic out_xfer;

`ifdef PIPE_REG_HS_SKID_EN

  // State encodes (main valid, skid valid) as {skid, main}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t         state, state_nxt;
  logic           p_ready_q, p_ready_nxt;
  logic [N-1:0]   main_data_p1;
  logic [N-1:0]   skid_data_p1;
  logic           ld_main_in, ld_main_skid, ld_skid;

  assign in_xfer  = p_valid && p_ready_q;
  assign out_xfer = state[0] && q_ready;

  // Next-state and load decode; flush empties the buffer and suppresses loads.
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt  = BUSY;
          ld_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          ld_main_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = FULL;
          ld_skid   = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt    = BUSY;
          ld_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
    p_ready_nxt = (state_nxt != FULL);
  end

  // State register and registered p_ready (no q_ready -> p_ready path).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      p_ready_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      p_ready_q <= p_ready_nxt;
    end
  end

  // Output data register: loaded from input or promoted from the skid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_p1 <= RESET_VAL;
    end else if (ld_main_in) begin
      main_data_p1 <= p_data;
    end else if (ld_main_skid) begin
      main_data_p1 <= skid_data_p1;
    end
  end

  // Skid data register: captures the one extra entry taken on a new stall.
  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_data_p1 <= p_data;
    end
  end

  assign p_ready = p_ready_q;
  assign q_valid = state[0];
  assign q_data  = main_data_p1;

`else

  logic           vld_p1;
  logic [N-1:0]   data_p1;

  assign p_ready  = !vld_p1 || q_ready;
  assign in_xfer  = p_valid && p_ready;
  assign out_xfer = vld_p1 && q_ready;

  // Single-entry register; flush drops the entry but keeps the data bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= RESET_VAL;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (in_xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= p_data;
    end else if (out_xfer) begin
      vld_p1  <= 1'b0;
    end
  end

  assign q_valid = vld_p1;
  assign q_data  = data_p1;

`endif

  // Stall counter: counts cycles the output is held back; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (q_valid && !q_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: doc/pipe_reg_hs.md
# pipe_reg_hs

Parametrised elastic pipeline register: the handshaked successor of the plain write-enabled flip-flop used between processor pipeline stages. It replaces the bare `wr` enable with a valid/ready handshake, adds a pipeline flush, a configurable data reset value, a saturating stall counter and an optional skid buffer for full throughput with a registered `p_ready`. It sits on every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) and gives hazard logic a uniform stall/flush interface.

## Interface
- `N`, 32, data width in bits
- `RESET_VAL`, `'0`, value loaded into `q_data` on reset
- `CNT_W`, 16, stall counter width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous; discards all held entries
- `p_valid`  in  1  upstream has data on `p_data`
- `p_ready`  out  1  block accepts `p_data` this cycle
- `p_data`  in  N  upstream data
- `q_valid`  out  1  `q_data` holds a valid entry
- `q_ready`  in  1  downstream consumes `q_data` this cycle
- `q_data`  out  N  registered output data
- `stall_cnt`  out  CNT_W  cycles with `q_valid && !q_ready`, saturating

## Operation
- Transfer in: `p_valid && p_ready` at a rising edge. Transfer out: `q_valid && q_ready`.
- Reset: `q_valid`=0, `q_data`=`RESET_VAL`, `stall_cnt`=0, skid entry invalid, `p_ready`=1 the cycle after reset.
- Base (no skid): one entry. `p_ready = !q_valid || q_ready` (combinational). On transfer in, `q_data <= p_data`, `q_valid <= 1`. On transfer out without transfer in, `q_valid <= 0`; `q_data` holds its last value.
- Skid variant states (main, skid valid bits):
  - EMPTY (0,0): `p_ready`=1; transfer in -> BUSY.
  - BUSY (1,0): `p_ready`=1; in and out -> BUSY (main replaced); in only -> FULL (input to skid); out only -> EMPTY.
  - FULL (1,1): `p_ready`=0; out -> BUSY (skid moves to main, skid invalid); else hold.
- Ordering strictly FIFO; no entry dropped or duplicated except by flush/reset.
- `q_data` stable while `q_valid && !q_ready`.
- Flush: next edge clears all valid bits; data registers keep contents; any same-cycle transfer in is discarded; `stall_cnt` unaffected. `p_ready` is 1 the cycle after flush.
- Priority: `reset` > `flush` > transfers.
- `stall_cnt`: +1 each cycle `q_valid && !q_ready`; saturates at 2^CNT_W-1; cleared only by reset.

## Timing
- Latency: 1 cycle from transfer in to `q_valid`/`q_data` visible.
- Throughput: 1 transfer/cycle sustained with `q_ready`=1 in both variants.
- Base: `p_ready` combinational from `q_ready` (one-cycle backpressure path).
- Skid: `p_ready` is a register output (no combinational `q_ready`->`p_ready` path); on a new stall it stays 1 for one more cycle and absorbs exactly one extra entry.
- Reset or flush mid-stall: entries lost, `q_valid`=0 next cycle; `q_ready` thereafter has no effect until a new transfer in.

## Configuration
- `PIPE_REG_HS_SKID_EN` defined: two-entry skid buffer, registered `p_ready`, FSM above.
- Undefined: single entry, combinational `p_ready`, no skid storage. Handshake semantics, flush, reset and `stall_cnt` identical in both builds.

## Test plan
- N=8, RESET_VAL='h5a: assert reset 1 cycle -> `q_data`='h5a, `q_valid`=0, `stall_cnt`=0, `p_ready`=1.
- `p_valid`=1 `p_data`='hac, `q_ready`=1 -> next cycle `q_valid`=1 `q_data`='hac; stream 'hac,'h00,'hcc back-to-back -> outputs same order, one per cycle.
- `q_ready`=0 with 'hcc held, `p_valid`=1 'hff for 3 cycles -> `q_data` stays 'hcc, `stall_cnt`=3; skid build: 'hff accepted once then `p_ready`=0; base: `p_ready`=0 immediately; release `q_ready` -> 'hcc then 'hff.
- FULL (skid build) + `flush`=1 with `p_valid`=1 'h11 -> next cycle `q_valid`=0, `p_ready`=1, 'h11 never appears, `stall_cnt` unchanged.
- CNT_W=2, hold stall 6 cycles -> `stall_cnt` reaches 3 and stays 3.
- `reset` and `flush` asserted together with transfer in 'h77 -> reset values, 'h77 dropped.
